pipe_reg_chain: RTL and testbench

- Parametrised chain of pipeline registers. It is the next-generation replacement for the per-signal stall-only flip-flops between core stages.
- It carries a WIDTH-bit payload through DEPTH stages with a valid bit per stage.
- It supports global memory stall, per-stage hold with automatic bubble insertion downstream, per-stage flush to NOP, and a saturating bubble counter.
- It sits between fetch and the execute/writeback stages of Riscv151. One instance replaces several parallel FlipFlop instances by packing inst/pc/imm/rs1/rs2 into WIDTH.

---
 rtl/pipe_reg_chain.sv | 111 +++++++++++
 tb/tb_pipe_reg_chain.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// Parametrised pipeline register chain with global stall, per-stage hold with
// downstream bubble insertion, per-stage flush to NOP and a saturating bubble counter.
module pipe_reg_chain #(
    parameter int          WIDTH = 32,
    parameter int          DEPTH = 3,
    parameter logic [31:0] NOP   = 32'h00000013,
    parameter int          CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [DEPTH-1:0]       hold,
    input  logic [DEPTH-1:0]       flush,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    output logic [CNT_W-1:0]       bubble_count
);

    localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP);

    logic [WIDTH-1:0] data_r   [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [WIDTH-1:0] data_nx  [DEPTH];
    logic [DEPTH-1:0] valid_nx;
    logic [WIDTH-1:0] up_data  [DEPTH];
    logic [DEPTH-1:0] up_valid;
    logic [DEPTH-1:0] up_frz;
    logic [DEPTH-1:0] frz;
    logic             bubble;
    logic [CNT_W-1:0] cnt_r;

    // A hold anywhere downstream freezes this stage too.
    always_comb begin
        frz = '0;
        for (int i = 0; i < DEPTH; i++) begin
            frz[i] = |(hold >> i);
        end
    end

    assign in_ready = !reset && !stall && !frz[0];

    always_comb begin
        up_data[0]  = in_data;
        up_valid    = '0;
        up_frz      = '0;
        up_valid[0] = in_valid;
        for (int i = 1; i < DEPTH; i++) begin
            up_data[i]  = data_r[i-1];
            up_valid[i] = valid_r[i-1];
            up_frz[i]   = frz[i-1];
        end
    end

    always_comb begin
        bubble   = 1'b0;
        valid_nx = valid_r;
        for (int i = 0; i < DEPTH; i++) begin
            data_nx[i] = data_r[i];
            if (flush[i]) begin
                data_nx[i]  = NOP_W;
                valid_nx[i] = 1'b0;
            end else if (frz[i]) begin
                data_nx[i]  = data_r[i];
            end else if (up_frz[i]) begin
                // Boundary stage directly below the highest held stage.
                data_nx[i]  = NOP_W;
                valid_nx[i] = 1'b0;
                bubble      = 1'b1;
            end else begin
                data_nx[i]  = up_valid[i] ? up_data[i] : NOP_W;
                valid_nx[i] = up_valid[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= NOP_W;
            end
            valid_r <= '0;
            cnt_r   <= '0;
        end else if (!stall) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= data_nx[i];
            end
            valid_r <= valid_nx;
            if (bubble && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    always_comb begin
        stage_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stage_data[i*WIDTH +: WIDTH] = data_r[i];
        end
    end

    assign stage_valid  = valid_r;
    assign out_data     = data_r[DEPTH-1];
    assign out_valid    = valid_r[DEPTH-1];
    assign bubble_count = cnt_r;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: a freeze-boundary reference model feeds
// expected snapshots into a queue that a negedge monitor drains and compares.
module tb_pipe_reg_chain;

    localparam int D  = 3;
    localparam int W  = 32;
    localparam int CW = 4;
    localparam logic [31:0] NOPV = 32'h00000013;

    logic           clk = 1'b0;
    logic           reset, stall, in_valid;
    logic [D-1:0]   hold, flush;
    logic [W-1:0]   in_data;
    logic           in_ready, out_valid;
    logic [D*W-1:0] stage_data;
    logic [D-1:0]   stage_valid;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  bubble_count;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .NOP(NOPV), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .hold(hold), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .stage_data(stage_data), .stage_valid(stage_valid),
        .out_data(out_data), .out_valid(out_valid), .bubble_count(bubble_count)
    );

    typedef struct {
        logic [D*W-1:0] sd;
        logic [D-1:0]   sv;
        logic [CW-1:0]  cnt;
        logic           rdy;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_data [D];
    logic [D-1:0] m_valid;
    int          m_cnt;

    task automatic chk(input string name, input logic [D*W-1:0] act, input logic [D*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: find the highest held index b; stages <= b freeze, stage b+1 bubbles,
    // everything else shifts down by one.
    task automatic model_edge(input logic r, input logic s, input logic [D-1:0] h,
                              input logic [D-1:0] f, input logic [31:0] d, input logic v);
        logic [31:0] od [D];
        logic [D-1:0] ov;
        int b;
        if (r) begin
            for (int i = 0; i < D; i++) m_data[i] = NOPV;
            m_valid = '0;
            m_cnt = 0;
            return;
        end
        if (s) return;
        od = m_data;
        ov = m_valid;
        b = -1;
        for (int j = 0; j < D; j++) if (h[j]) b = j;
        for (int i = 0; i < D; i++) begin
            logic [31:0] id;
            logic iv;
            id = (i == 0) ? d : od[(i == 0) ? 0 : i-1];
            iv = (i == 0) ? v : ov[(i == 0) ? 0 : i-1];
            if (f[i]) begin
                m_data[i] = NOPV; m_valid[i] = 1'b0;
            end else if (i <= b) begin
                m_data[i] = od[i]; m_valid[i] = ov[i];
            end else if (b >= 0 && i == b + 1) begin
                m_data[i] = NOPV; m_valid[i] = 1'b0;
            end else begin
                m_data[i] = iv ? id : NOPV; m_valid[i] = iv;
            end
        end
        if (b >= 0 && b < D - 1 && !f[b+1] && m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    // Called at posedge+1: drives inputs for the next edge and queues the expected view.
    task automatic step(input logic r, input logic s, input logic [D-1:0] h,
                        input logic [D-1:0] f, input logic [31:0] d, input logic v);
        exp_t e;
        reset = r; stall = s; hold = h; flush = f; in_data = d; in_valid = v;
        for (int i = 0; i < D; i++) e.sd[i*W +: W] = m_data[i];
        e.sv  = m_valid;
        e.cnt = CW'(m_cnt);
        e.rdy = !r && !s && (h == '0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        model_edge(r, s, h, f, d, v);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("stage_data", stage_data, e.sd);
            chk("stage_valid", D*W'(stage_valid), D*W'(e.sv));
            chk("bubble_count", D*W'(bubble_count), D*W'(e.cnt));
            chk("in_ready", D*W'(in_ready), D*W'(e.rdy));
            chk("out_data", D*W'(out_data), D*W'(e.sd[(D-1)*W +: W]));
            chk("out_valid", D*W'(out_valid), D*W'(e.sv[D-1]));
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; hold = '0; flush = '0;
        in_data = 32'hAAAA0000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        model_edge(1'b1, 1'b0, '0, '0, 32'hAAAA0000, 1'b1);

        // Reset with valid input pending
        step(1, 0, 3'b000, 3'b000, 32'hAAAA0000, 1);
        step(1, 0, 3'b000, 3'b000, 32'hAAAA0000, 1);
        chk("reset_data", stage_data, {3{NOPV}});
        chk("reset_cnt", D*W'(bubble_count), '0);

        // Stream A..D
        step(0, 0, 3'b000, 3'b000, 32'h100, 1);
        step(0, 0, 3'b000, 3'b000, 32'h104, 1);
        step(0, 0, 3'b000, 3'b000, 32'h108, 1);
        chk("latency_A", D*W'(out_data), D*W'(32'h100));
        step(0, 0, 3'b000, 3'b000, 32'h10C, 1);
        chk("stream_B", D*W'(out_data), D*W'(32'h104));

        // Stall with flush pulsed, then resume
        step(0, 1, 3'b000, 3'b111, 32'h110, 1);
        step(0, 1, 3'b000, 3'b111, 32'h110, 1);
        chk("stall_keep", stage_data, {32'h104, 32'h108, 32'h10C});
        step(0, 0, 3'b000, 3'b000, 32'h110, 1);
        step(0, 0, 3'b000, 3'b000, 32'h114, 1);

        // Hold middle stage, then flush with hold
        step(0, 0, 3'b010, 3'b000, 32'h118, 1);
        chk("hold_bubble", D*W'(bubble_count), D*W'(4'd1));
        step(0, 0, 3'b010, 3'b011, 32'h118, 1);
        chk("flush_hold", stage_data, {3{NOPV}});
        chk("flush_hold_cnt", D*W'(bubble_count), D*W'(4'd2));

        // Saturation and reset
        for (int k = 0; k < 20; k++) step(0, 0, 3'b001, 3'b000, $urandom, 1);
        chk("saturate", D*W'(bubble_count), D*W'(4'd15));
        step(1, 0, 3'b000, 3'b000, 32'h0, 0);
        chk("sat_reset", D*W'(bubble_count), '0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            logic r, s, v;
            logic [D-1:0] h, f;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 10);
            h = ($urandom_range(0, 99) < 15) ? D'($urandom_range(1, 7)) : '0;
            f = ($urandom_range(0, 99) < 8)  ? D'($urandom_range(1, 7)) : '0;
            v = ($urandom_range(0, 99) < 80);
            step(r, s, h, f, $urandom, v);
        end
        step(0, 0, 3'b000, 3'b000, 32'h0, 0);

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
